inst_fetch_seq: RTL and testbench
=================================

# inst_fetch_seq

Parametrised program-sequencing fetch unit: owns the program counter, sequences consecutive programs on `start`, applies conditional absolute or PC-relative branches, honours a pipeline stall, and detects program end. Sits between the top-level controller and the combinational instruction ROM, replacing the fixed 11-bit fetch unit, and adds a run/halt state machine and a saturating cycle counter.

## Interface
- `PC_W`, 11, program counter and ROM address width
- `INST_W`, 9, instruction width from ROM
- `CYC_W`, 16, cycle counter width
- `REL_BR`, 1, 1 = target is signed PC-relative offset, 0 = absolute address
- `HALT_INST`, 9'b111111111, instruction encoding that ends a program
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low; forces all state to reset values
- `start`  in  1  single-cycle pulse: begin program at `start_addr`
- `start_addr`  in  PC_W  first address of the program to run
- `stall`  in  1  freeze PC and counter for this cycle
- `branch_en`  in  1  current instruction is a conditional branch
- `alu_flag`  in  1  branch condition from ALU
- `target`  in  PC_W  branch target (offset or absolute, per `REL_BR`)
- `inst_in`  in  INST_W  ROM data at `prog_ctr` (combinational)
- `prog_ctr`  out  PC_W  program counter / ROM address
- `running`  out  1  high in RUN
- `done`  out  1  high in HALT until next `start`
- `cycle_ct`  out  CYC_W  RUN cycles elapsed, saturating

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- IDLE: PC held. `start` -> RUN, `prog_ctr <= start_addr`, `cycle_ct <= 0`.
- RUN, per non-stalled cycle, priority order:
  - `start` -> restart: `prog_ctr <= start_addr`, `cycle_ct <= 0`, stay RUN.
  - `inst_in == HALT_INST` -> HALT; PC holds on halt address; counter not incremented.
  - `branch_en && alu_flag` -> `prog_ctr <= REL_BR ? prog_ctr + target : target`.
  - else `prog_ctr <= prog_ctr + 1`.
  - `cycle_ct` increments unless at all-ones.
- Branch with `branch_en=1, alu_flag=0` falls through (+1).
- Relative arithmetic: `target` two's complement, sum truncated to PC_W (modulo 2^PC_W). Sequential increment also wraps: all-ones -> 0.
- `stall` in RUN: PC, state, counter hold; halt and branch ignored that cycle. `start` overrides `stall`.
- HALT: PC and counter hold; `done=1`. `start` -> RUN as from IDLE (next program in series).
- `start` in IDLE/HALT while `stall` high: start still taken.

## Timing
- Reset values: `prog_ctr=0`, `running=0`, `done=0`, `cycle_ct=0`, state IDLE; applied immediately on `reset` low, independent of `clk`.
- `start` sampled at edge N -> `prog_ctr=start_addr` and `running=1` after edge N; ROM data for that address valid same cycle.
- Branch decision uses inputs in cycle N; new PC visible after edge N (one-cycle redirect, no delay slot).
- `done` rises on the edge where halt is detected; `running` falls on same edge.
- All outputs registered; no combinational path input -> output.
- Reset asserted mid-RUN: aborts program, IDLE, counter cleared; no trace of prior program.

## Structure
- Shared package: state enum (IDLE/RUN/HALT), default `PC_W`/`INST_W`, `HALT_INST` encoding, shared with control decoder.
- One sub-module natural: `pc_next_calc` (combinational next-PC mux: increment / absolute / relative, wrap). FSM, counter in top.

## Test plan
- Reset low mid-run at PC=5 -> `prog_ctr=0`, `running=0`, `cycle_ct=0` without clock edge; stays IDLE after release until `start`.
- `start` with `start_addr=0x010`, no branches, no halt for 4 cycles -> PC 0x010,0x011,0x012,0x013; `cycle_ct` 0..3.
- `REL_BR=1`, PC=0x020, `branch_en=1,alu_flag=1,target=11'h7FC` (-4) -> next PC 0x01C; same with `alu_flag=0` -> 0x021.
- `REL_BR=0`, PC=0x7FF, no branch -> wraps to 0x000; absolute branch `target=0x100` -> 0x100.
- `stall` held 3 cycles at PC=0x030 with taken branch asserted -> PC stays 0x030, counter frozen; after release branch takes effect.
- ROM returns `HALT_INST` at 0x040 -> `done=1`, PC stays 0x040; `start` with `start_addr=0x200` -> RUN at 0x200, `done=0`, `cycle_ct=0`; `CYC_W=4` run of 20 cycles saturates at 15.

Source files
------------

// File: rtl/inst_fetch_seq_pkg.sv
// Shared fetch-sequencer definitions: run/halt state encoding and default widths,
// also used by the control decoder.
package inst_fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int          DEF_PC_W      = 11;
    localparam int          DEF_INST_W    = 9;
    localparam int          DEF_CYC_W     = 16;
    localparam logic [8:0]  DEF_HALT_INST = 9'b111111111;

endpackage

// File: rtl/inst_fetch_seq_pc_next_calc.sv
// Combinational next-PC select: sequential increment or taken branch (absolute or
// PC-relative). All arithmetic wraps modulo 2^PC_W.
module inst_fetch_seq_pc_next_calc #(
    parameter int PC_W   = 11,
    parameter int REL_BR = 1
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_target,
    input  logic            i_take_br,
    output logic [PC_W-1:0] o_pc_next
);

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_br;

    // Two's complement offset: plain truncated addition gives the signed result.
    assign w_pc_inc  = i_pc + PC_W'(1);
    assign w_pc_br   = (REL_BR != 0) ? (i_pc + i_target) : i_target;
    assign o_pc_next = i_take_br ? w_pc_br : w_pc_inc;

endmodule

// File: rtl/inst_fetch_seq.sv
// Program fetch sequencer: owns the PC, runs programs back to back on start,
// applies conditional branches, honours stall, and halts on the end encoding.
module inst_fetch_seq
    import inst_fetch_seq_pkg::*;
#(
    parameter int               PC_W      = DEF_PC_W,
    parameter int               INST_W    = DEF_INST_W,
    parameter int               CYC_W     = DEF_CYC_W,
    parameter int               REL_BR    = 1,
    parameter logic [INST_W-1:0] HALT_INST = INST_W'(DEF_HALT_INST)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [PC_W-1:0]   i_start_addr,
    input  logic              i_stall,
    input  logic              i_branch_en,
    input  logic              i_alu_flag,
    input  logic [PC_W-1:0]   i_target,
    input  logic [INST_W-1:0] i_inst_in,
    output logic [PC_W-1:0]   o_prog_ctr,
    output logic              o_running,
    output logic              o_done,
    output logic [CYC_W-1:0]  o_cycle_ct
);

    fetch_state_e     r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt, w_pc_calc;
    logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
    logic             r_running, w_running_nxt;
    logic             r_done, w_done_nxt;

    inst_fetch_seq_pc_next_calc #(
        .PC_W   (PC_W),
        .REL_BR (REL_BR)
    ) u_pc_next (
        .i_pc      (r_pc),
        .i_target  (i_target),
        .i_take_br (i_branch_en & i_alu_flag),
        .o_pc_next (w_pc_calc)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_cyc     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_cyc     <= w_cyc_nxt;
            r_running <= w_running_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // start wins over everything, including stall, in every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cyc_nxt     = r_cyc;
        w_running_nxt = r_running;
        w_done_nxt    = r_done;
        if (i_start) begin
            w_state_nxt   = ST_RUN;
            w_pc_nxt      = i_start_addr;
            w_cyc_nxt     = '0;
            w_running_nxt = 1'b1;
            w_done_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!i_stall) begin
                        if (i_inst_in == HALT_INST) begin
                            w_state_nxt   = ST_HALT;
                            w_running_nxt = 1'b0;
                            w_done_nxt    = 1'b1;
                        end else begin
                            w_pc_nxt = w_pc_calc;
                            if (r_cyc != {CYC_W{1'b1}})
                                w_cyc_nxt = r_cyc + CYC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_prog_ctr = r_pc;
    assign o_running  = r_running;
    assign o_done     = r_done;
    assign o_cycle_ct = r_cyc;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq: a relative-branch instance with a 4-bit counter and an
// absolute-branch instance with the default counter, both against a behavioural model.
module tb_inst_fetch_seq;

    localparam logic [8:0] HALT = 9'h1FF;

    logic        clk = 1'b0;
    logic        reset, start, stall, branch_en, alu_flag;
    logic [10:0] start_addr, target;
    logic [8:0]  rom [0:2047];

    logic [10:0] pc0, pc1;
    logic        run0, run1, done0, done1;
    logic [3:0]  cyc0;
    logic [15:0] cyc1;
    logic [8:0]  inst0, inst1;

    assign inst0 = rom[pc0];
    assign inst1 = rom[pc1];

    always #5 clk = ~clk;

    inst_fetch_seq #(.PC_W(11), .INST_W(9), .CYC_W(4), .REL_BR(1), .HALT_INST(HALT)) dut0 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_start_addr(start_addr),
        .i_stall(stall), .i_branch_en(branch_en), .i_alu_flag(alu_flag), .i_target(target),
        .i_inst_in(inst0), .o_prog_ctr(pc0), .o_running(run0), .o_done(done0), .o_cycle_ct(cyc0)
    );

    inst_fetch_seq #(.PC_W(11), .INST_W(9), .CYC_W(16), .REL_BR(0), .HALT_INST(HALT)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_start_addr(start_addr),
        .i_stall(stall), .i_branch_en(branch_en), .i_alu_flag(alu_flag), .i_target(target),
        .i_inst_in(inst1), .o_prog_ctr(pc1), .o_running(run1), .o_done(done1), .o_cycle_ct(cyc1)
    );

    // Behavioural model: index 0 mirrors dut0 (relative, 4-bit counter), 1 mirrors dut1.
    int m_pc [2];
    int m_cyc [2];
    bit m_run [2];
    bit m_done [2];
    int cyc_max [2] = '{15, 65535};
    bit rel [2] = '{1'b1, 1'b0};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".pc0"},   32'(pc0),   m_pc[0]);
        chk({ph, ".run0"},  32'(run0),  32'(m_run[0]));
        chk({ph, ".done0"}, 32'(done0), 32'(m_done[0]));
        chk({ph, ".cyc0"},  32'(cyc0),  m_cyc[0]);
        chk({ph, ".pc1"},   32'(pc1),   m_pc[1]);
        chk({ph, ".run1"},  32'(run1),  32'(m_run[1]));
        chk({ph, ".done1"}, 32'(done1), 32'(m_done[1]));
        chk({ph, ".cyc1"},  32'(cyc1),  m_cyc[1]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_cyc[k] = 0; m_run[k] = 0; m_done[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (start) begin
                m_pc[k] = int'(start_addr); m_cyc[k] = 0; m_run[k] = 1; m_done[k] = 0;
            end else if (m_run[k] && !stall) begin
                if (rom[m_pc[k]] == HALT) begin
                    m_run[k] = 0; m_done[k] = 1;
                end else begin
                    if (branch_en && alu_flag)
                        m_pc[k] = rel[k] ? (m_pc[k] + int'(target)) % 2048 : int'(target);
                    else
                        m_pc[k] = (m_pc[k] + 1) % 2048;
                    if (m_cyc[k] < cyc_max[k]) m_cyc[k]++;
                end
            end
        end
    endtask

    task automatic step(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic quiet();
        start = 0; stall = 0; branch_en = 0; alu_flag = 0; target = '0; start_addr = '0;
    endtask

    task automatic do_start(input logic [10:0] a, input string ph);
        quiet(); start = 1; start_addr = a;
        step(ph);
        start = 0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 9'h000;
        quiet();
        reset = 0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk); #1;
        reset = 1;
        step("idle0");
        step("idle1");

        // Sequential run from 0x010.
        do_start(11'h010, "seq_start");
        chk("seq_pc_first", 32'(pc1), 32'h010);
        for (int i = 0; i < 3; i++) step("seq");
        chk("seq_pc_last", 32'(pc1), 32'h013);
        chk("seq_cyc_last", 32'(cyc1), 3);

        // Taken branch, -4 offset on the relative instance.
        do_start(11'h020, "br_start");
        branch_en = 1; alu_flag = 1; target = 11'h7FC;
        step("br_taken");
        chk("rel_br_taken", 32'(pc0), 32'h01C);
        chk("abs_br_taken", 32'(pc1), 32'h7FC);
        do_start(11'h020, "br_start2");
        branch_en = 1; alu_flag = 0; target = 11'h7FC;
        step("br_not_taken");
        chk("rel_br_fallthru", 32'(pc0), 32'h021);

        // Wrap at top of address space, then absolute branch.
        do_start(11'h7FF, "wrap_start");
        step("wrap");
        chk("wrap_pc", 32'(pc1), 32'h000);
        branch_en = 1; alu_flag = 1; target = 11'h100;
        step("abs_br");
        chk("abs_br_pc", 32'(pc1), 32'h100);

        // Stall holds a pending taken branch.
        do_start(11'h030, "stall_start");
        stall = 1; branch_en = 1; alu_flag = 1; target = 11'h005;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_pc", 32'(pc1), 32'h030);
        stall = 0;
        step("stall_release");
        chk("stall_release_pc", 32'(pc1), 32'h005);
        chk("stall_release_pc_rel", 32'(pc0), 32'h035);

        // Halt at 0x040, hold, then chain into the next program (start during stall).
        rom[11'h040] = HALT;
        do_start(11'h03E, "halt_start");
        for (int i = 0; i < 5; i++) step("halt_run");
        chk("halt_pc", 32'(pc1), 32'h040);
        chk("halt_done", 32'(done1), 1);
        chk("halt_cyc", 32'(cyc1), 2);
        quiet(); start = 1; stall = 1; start_addr = 11'h200;
        step("restart");
        chk("restart_pc", 32'(pc1), 32'h200);
        chk("restart_done", 32'(done1), 0);
        quiet();

        // Counter saturation on the 4-bit instance.
        do_start(11'h300, "sat_start");
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat_cyc0", 32'(cyc0), 15);
        chk("sat_cyc1", 32'(cyc1), 20);

        // Asynchronous reset mid-run at PC=5.
        do_start(11'h003, "rst_start");
        step("rst_run");
        step("rst_run");
        chk("rst_pre_pc", 32'(pc1), 32'h005);
        #2;
        reset = 0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk); #1;
        reset = 1;
        for (int i = 0; i < 3; i++) step("post_rst_idle");

        // Randomised phase with sparse halts in ROM.
        for (int i = 0; i < 2048; i++)
            rom[i] = ($urandom_range(0, 19) == 0) ? HALT : 9'($urandom_range(0, 510));
        for (int n = 0; n < 400; n++) begin
            start      = ($urandom_range(0, 15) == 0);
            start_addr = 11'($urandom);
            stall      = ($urandom_range(0, 4) == 0);
            branch_en  = 1'($urandom);
            alu_flag   = 1'($urandom);
            target     = 11'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
